// File: rtl/instr_encoder_if.sv
// Command-in / IMEM-write-out bundle between the program loader and instr_encoder.
// The loader side takes the master modport and the encoder takes the slave modport.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd_class;
    logic [1:0]        i_cmd_func;
    logic [3:0]        i_cmd_rd;
    logic [3:0]        i_cmd_rs;
    logic [3:0]        i_cmd_rt;
    logic [11:0]       i_cmd_imm;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [15:0]       o_imem_wdata;

    modport master (
        output i_cmd_valid, i_cmd_class, i_cmd_func, i_cmd_rd, i_cmd_rs, i_cmd_rt, i_cmd_imm,
        input  o_cmd_ready, o_imem_we, o_imem_addr, o_imem_wdata
    );

    modport slave (
        input  i_cmd_valid, i_cmd_class, i_cmd_func, i_cmd_rd, i_cmd_rs, i_cmd_rt, i_cmd_imm,
        output o_cmd_ready, o_imem_we, o_imem_addr, o_imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs command-stream entries into 16-bit instruction words and writes them sequentially
// into IMEM, inserting NOP padding after every branch (BAF) word.
module instr_encoder #(
    parameter int          ADDR_W     = 8,
    parameter int          BRANCH_PAD = 1,
    parameter logic [15:0] NOP_WORD   = 16'h8000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_finish,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_done,
    output logic              o_overflow
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PAD  = 3'd2,
        S_DONE = 3'd3,
        S_FULL = 3'd4
    } state_t;

    localparam logic [1:0] CLS_BAF  = 2'b11;
    localparam logic [1:0] CLS_IMM  = 2'b10;
    localparam bit         HAS_PAD  = (BRANCH_PAD > 0);
    localparam logic [1:0] PAD_LAST = HAS_PAD ? 2'(BRANCH_PAD - 1) : 2'd0;

    state_t            state_q, state_d;
    logic [1:0]        pad_cnt_q, pad_cnt_d;
    logic              fin_pend_q, fin_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;

    logic launch_cmd;
    logic launch_pad;
    logic launch;
    logic at_top;
    logic cmd_is_baf;

    function automatic logic [15:0] encode(
        input logic [1:0]  cls,
        input logic [1:0]  func,
        input logic [3:0]  rd,
        input logic [3:0]  rs,
        input logic [3:0]  rt,
        input logic [11:0] imm
    );
        case (cls)
            CLS_IMM: encode = {cls, func, rd, imm[7:0]};
            CLS_BAF: encode = {cls, func, imm};
            default: encode = {cls, func, rd, rs, rt};
        endcase
    endfunction

    // Ready is a pure function of the registered state, so acceptance is valid && RUN.
    assign launch_cmd = (state_q == S_RUN) && bus.i_cmd_valid;
    assign launch_pad = (state_q == S_PAD) && !i_start;
    assign launch     = launch_cmd || launch_pad;
    assign at_top     = (addr_q == {ADDR_W{1'b1}});
    assign cmd_is_baf = (bus.i_cmd_class == CLS_BAF);

    // ---- state register ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pad_cnt_q  <= 2'd0;
            fin_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_cnt_q  <= pad_cnt_d;
            fin_pend_q <= fin_pend_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d    = state_q;
        pad_cnt_d  = pad_cnt_q;
        fin_pend_d = fin_pend_q;
        if (i_start) begin
            state_d    = S_RUN;
            pad_cnt_d  = 2'd0;
            fin_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (launch_cmd && at_top) begin
                        state_d = S_FULL;
                    end else if (launch_cmd && cmd_is_baf && HAS_PAD) begin
                        state_d    = S_PAD;
                        pad_cnt_d  = 2'd0;
                        fin_pend_d = i_finish;
                    end else if (i_finish) begin
                        state_d = S_DONE;
                    end
                end
                S_PAD: begin
                    // A finish seen while padding is held until the last pad word.
                    pad_cnt_d  = pad_cnt_q + 2'd1;
                    fin_pend_d = fin_pend_q || i_finish;
                    if (at_top) begin
                        state_d = S_FULL;
                    end else if (pad_cnt_q == PAD_LAST) begin
                        state_d = (fin_pend_q || i_finish) ? S_DONE : S_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // ---- output logic ----
    always_comb begin
        bus.o_cmd_ready = (state_q == S_RUN);
        o_done          = (state_q == S_DONE);
        o_overflow      = (state_q == S_FULL);
    end

    // ---- write stage ----
    always_comb begin
        we_d    = launch;
        waddr_d = launch ? addr_q : waddr_q;
        wdata_d = wdata_q;
        if (launch_pad) begin
            wdata_d = NOP_WORD;
        end else if (launch_cmd) begin
            wdata_d = encode(bus.i_cmd_class, bus.i_cmd_func, bus.i_cmd_rd,
                             bus.i_cmd_rs, bus.i_cmd_rt, bus.i_cmd_imm);
        end
        if (i_start) begin
            addr_d = i_base_addr;
            cnt_d  = '0;
        end else if (launch) begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            cnt_d  = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            addr_d = addr_q;
            cnt_d  = cnt_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.o_imem_we    = we_q;
    assign bus.o_imem_addr  = waddr_q;
    assign bus.o_imem_wdata = wdata_q;
    assign o_word_count     = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed command sequences push expected IMEM writes,
// a negedge monitor pops and compares every write strobe.
module tb_instr_encoder;

    localparam int ADDR_W = 8;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [8:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base = 8'h00;
    logic        finish = 1'b0;
    logic [8:0]  word_count;
    logic        done;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .BRANCH_PAD(1), .NOP_WORD(16'h8000)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_base_addr  (base),
        .i_finish     (finish),
        .bus          (bus.slave),
        .o_word_count (word_count),
        .o_done       (done),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] cls, input logic [1:0] func,
                           input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                           input logic [11:0] imm);
        bus.i_cmd_valid = v;
        bus.i_cmd_class = cls;
        bus.i_cmd_func  = func;
        bus.i_cmd_rd    = rd;
        bus.i_cmd_rs    = rs;
        bus.i_cmd_rt    = rt;
        bus.i_cmd_imm   = imm;
    endtask

    task automatic push(input logic [7:0] a, input logic [15:0] d, input logic [8:0] c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cnt  = c;
        q.push_back(e);
    endtask

    task automatic begin_session(input logic [7:0] b);
        start = 1'b1;
        base  = b;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_imem_we === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0h data=%0h", bus.o_imem_addr, bus.o_imem_wdata);
                end else begin
                    e = q.pop_front();
                    check("wr_addr", 32'(bus.o_imem_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.o_imem_wdata), 32'(e.data));
                    check("wr_count", 32'(word_count), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_cmd(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 12'h000);
        #12;
        // Reset state
        check("rst_we", 32'(bus.o_imem_we), 0);
        check("rst_ready", 32'(bus.o_cmd_ready), 0);
        check("rst_count", 32'(word_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(bus.o_cmd_ready), 0);

        // LDA func=01 rd=3 rs=4 rt=5 -> 1345 @10
        begin_session(8'h10);
        check("run_ready", 32'(bus.o_cmd_ready), 1);
        push(8'h10, 16'h1345, 9'd1);
        set_cmd(1'b1, 2'b00, 2'b01, 4'h3, 4'h4, 4'h5, 12'h000);
        tick();
        set_cmd(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 12'h000);

        // IMM rd=2 imm=A5, BAF target=123, pad, then held LDA
        begin_session(8'h10);
        push(8'h10, 16'h82A5, 9'd1);
        set_cmd(1'b1, 2'b10, 2'b00, 4'h2, 4'h0, 4'h0, 12'h0A5);
        tick();
        push(8'h11, 16'hC123, 9'd2);
        push(8'h12, 16'h8000, 9'd3);
        set_cmd(1'b1, 2'b11, 2'b00, 4'h0, 4'h0, 4'h0, 12'h123);
        tick();
        push(8'h13, 16'h0123, 9'd4);
        set_cmd(1'b1, 2'b00, 2'b00, 4'h1, 4'h2, 4'h3, 12'h000);
        check("pad_ready", 32'(bus.o_cmd_ready), 0);
        tick();
        check("post_pad_ready", 32'(bus.o_cmd_ready), 1);
        tick();
        set_cmd(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 12'h000);
        tick();
        check("run_count", 32'(word_count), 4);

        // Full boundary from base FE
        begin_session(8'hFE);
        push(8'hFE, 16'h4123, 9'd1);
        set_cmd(1'b1, 2'b01, 2'b00, 4'h1, 4'h2, 4'h3, 12'h000);
        tick();
        push(8'hFF, 16'h5456, 9'd2);
        set_cmd(1'b1, 2'b01, 2'b01, 4'h4, 4'h5, 4'h6, 12'h000);
        tick();
        set_cmd(1'b1, 2'b01, 2'b00, 4'h7, 4'h8, 4'h9, 12'h000);
        check("full_ready", 32'(bus.o_cmd_ready), 0);
        check("full_ovf", 32'(overflow), 1);
        tick();
        tick();
        set_cmd(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 12'h000);
        check("full_ovf_held", 32'(overflow), 1);
        check("full_count", 32'(word_count), 2);
        begin_session(8'h20);
        check("restart_ovf", 32'(overflow), 0);
        check("restart_ready", 32'(bus.o_cmd_ready), 1);
        check("restart_count", 32'(word_count), 0);

        // finish together with BAF: branch + pad, then DONE
        push(8'h20, 16'hD0AB, 9'd1);
        push(8'h21, 16'h8000, 9'd2);
        set_cmd(1'b1, 2'b11, 2'b01, 4'h0, 4'h0, 4'h0, 12'h0AB);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        set_cmd(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 12'h000);
        check("fin_pad_ready", 32'(bus.o_cmd_ready), 0);
        check("fin_pad_done", 32'(done), 0);
        tick();
        check("done_set", 32'(done), 1);
        check("done_ready", 32'(bus.o_cmd_ready), 0);
        set_cmd(1'b1, 2'b00, 2'b00, 4'h1, 4'h1, 4'h1, 12'h000);
        tick();
        tick();
        set_cmd(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 12'h000);
        check("done_held", 32'(done), 1);
        check("done_count", 32'(word_count), 2);

        // Reset asserted mid-PAD
        begin_session(8'h30);
        push(8'h30, 16'hC055, 9'd1);
        set_cmd(1'b1, 2'b11, 2'b00, 4'h0, 4'h0, 4'h0, 12'h055);
        tick();
        set_cmd(1'b0, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 12'h000);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_we", 32'(bus.o_imem_we), 0);
        check("arst_addr", 32'(bus.o_imem_addr), 0);
        check("arst_wdata", 32'(bus.o_imem_wdata), 0);
        check("arst_count", 32'(word_count), 0);
        check("arst_ready", 32'(bus.o_cmd_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_ready", 32'(bus.o_cmd_ready), 0);
        check("post_rst_count", 32'(word_count), 0);
        check("queue_empty", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
